iuq_btb_gen: RTL and testbench



---
 rtl/iuq_btb_gen.sv | 101 ++++++++++
 tb/tb_iuq_btb_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iuq_btb_gen.sv
// rtl/iuq_btb_gen.sv - BTB storage array: two-cycle registered read, write port, init sweep, optional parity
module iuq_btb_gen #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 43,
  parameter int AUTO_INIT  = 1,
  parameter int PARITY     = 1
) (
  input  logic                  nclk,
  input  logic                  rst,
  input  logic                  r_act,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic                  w_act,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  init_req,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  rd_perr,
  output logic                  init_busy,
  output logic                  w_drop
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int ENTRY_W = DATA_WIDTH + ((PARITY != 0) ? 1 : 0);

  typedef enum logic {IDLE, INIT} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [ENTRY_W-1:0]      mem [DEPTH];
  logic [ENTRY_W-1:0]      func_entry;
  logic [ENTRY_W-1:0]      wr_entry;
  logic [ENTRY_W-1:0]      rd_entry;
  logic                    perr_calc;
  logic                    sweep_we;
  logic                    func_we;
  logic                    rd_pend;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;

  always_ff @(posedge nclk or posedge rst) begin
    if (rst) begin
      state <= (AUTO_INIT != 0) ? INIT : IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_req) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        INIT: begin
          if (&cnt) state <= IDLE;
          else      cnt   <= cnt + 1'b1;
        end
      endcase
    end
  end

  assign init_busy = (state == INIT);
  assign sweep_we  = (state == INIT) & ~rst;
  assign func_we   = w_act & (state == IDLE) & ~rst;
  assign w_drop    = w_act & (state == INIT) & ~rst;

  // Parity is folded into the entry so a whole-entry XOR reports a mismatch directly.
  generate
    if (PARITY != 0) begin : g_par
      assign func_entry = {^data_in, data_in};
      assign perr_calc  = ^rd_entry;
    end else begin : g_nopar
      assign func_entry = data_in;
      assign perr_calc  = 1'b0;
    end
  endgenerate

  assign wr_entry = sweep_we ? '0 : func_entry;

  always_ff @(posedge nclk) begin
    if (sweep_we || func_we) mem[sweep_we ? cnt : w_addr] <= wr_entry;
  end

  // Array is read one cycle after the request, so writes up to the request cycle are visible.
  assign rd_entry = mem[rd_addr_q];

  always_ff @(posedge nclk or posedge rst) begin
    if (rst) begin
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      rd_valid  <= 1'b0;
      rd_perr   <= 1'b0;
      data_out  <= '0;
    end else begin
      rd_pend  <= r_act;
      if (r_act) rd_addr_q <= r_addr;
      rd_valid <= rd_pend;
      rd_perr  <= rd_pend & perr_calc;
      if (rd_pend) data_out <= rd_entry[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_iuq_btb_gen.sv
// tb/tb_iuq_btb_gen.sv - scoreboard bench for iuq_btb_gen
module tb_iuq_btb_gen;

  logic        nclk = 1'b0;
  logic        rst;
  logic        r_act;
  logic [5:0]  r_addr;
  logic        w_act;
  logic [5:0]  w_addr;
  logic [42:0] data_in;
  logic        init_req;
  logic [42:0] data_out;
  logic        rd_valid;
  logic        rd_perr;
  logic        init_busy;
  logic        w_drop;

  int total = 0;
  int bad   = 0;

  logic [42:0] model [64];
  logic        mperr [64];
  logic        tb_busy;
  logic [43:0] exp_q [$];
  logic [43:0] corrupt;

  iuq_btb_gen #(.ADDR_WIDTH(6), .DATA_WIDTH(43), .AUTO_INIT(1), .PARITY(1)) dut (
    .nclk(nclk), .rst(rst), .r_act(r_act), .r_addr(r_addr), .w_act(w_act),
    .w_addr(w_addr), .data_in(data_in), .init_req(init_req), .data_out(data_out),
    .rd_valid(rd_valid), .rd_perr(rd_perr), .init_busy(init_busy), .w_drop(w_drop)
  );

  always #5 nclk = ~nclk;

  always @(negedge nclk) begin
    logic [43:0] e;
    if (!rst) begin
      if (rd_valid) begin
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL rd_unexpected: rd_valid=1 data_out=%h with no read outstanding", data_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e[42:0]) begin
            bad = bad + 1;
            $display("FAIL rd_data: got %h want %h", data_out, e[42:0]);
          end
          total = total + 1;
          if (rd_perr !== e[43]) begin
            bad = bad + 1;
            $display("FAIL rd_perr: got %b want %b", rd_perr, e[43]);
          end
        end
      end else begin
        total = total + 1;
        if (rd_perr !== 1'b0) begin
          bad = bad + 1;
          $display("FAIL rd_perr_idle: got %b want 0", rd_perr);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [5:0] ra, input logic w,
                       input logic [5:0] wa, input logic [42:0] d, input logic ir);
    r_act = r; r_addr = ra; w_act = w; w_addr = wa; data_in = d; init_req = ir;
    if (w && !tb_busy) begin
      model[wa] = d;
      mperr[wa] = 1'b0;
    end
    if (r) exp_q.push_back({mperr[ra], model[ra]});
  endtask

  task automatic step(input logic r, input logic [5:0] ra, input logic w,
                      input logic [5:0] wa, input logic [42:0] d, input logic ir);
    drive(r, ra, w, wa, d, ir);
    @(negedge nclk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) begin
      model[i] = '0;
      mperr[i] = 1'b0;
    end
    tb_busy = 1'b0;
  endtask

  task automatic count_sweep(input string name);
    int cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (!init_busy) break;
      cnt++;
      @(negedge nclk);
    end
    total = total + 1;
    if (cnt != 64) begin
      bad = bad + 1;
      $display("FAIL %s: init_busy cycles=%0d want 64", name, cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tb_busy = 1'b1;
    drive(0, 0, 0, 0, '0, 0);
    repeat (3) @(negedge nclk);
    total = total + 1;
    if ({rd_valid, rd_perr, w_drop, data_out} !== '0) begin
      bad = bad + 1;
      $display("FAIL reset_outs: valid=%b perr=%b drop=%b data=%h want all 0",
               rd_valid, rd_perr, w_drop, data_out);
    end
    rst = 1'b0;
    count_sweep("reset_sweep");
    clear_model();
    for (int i = 0; i < 64; i++) step(1, 6'(i), 0, 0, '0, 0);
    repeat (3) step(0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_forward();
    step(0, 0, 1, 5, 43'h0AA, 0);
    step(1, 5, 0, 0, '0, 0);
    step(1, 5, 1, 5, 43'h1_2345_6789, 0);
    step(1, 5, 1, 5, 43'h777, 0);
    repeat (3) step(0, 0, 0, 0, '0, 0);
    step(1, 5, 0, 0, '0, 0);
    total = total + 1;
    if (rd_valid !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL lat_n1: rd_valid=%b want 0", rd_valid);
    end
    step(0, 0, 0, 0, '0, 0);
    total = total + 1;
    if (rd_valid !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL lat_n2: rd_valid=%b want 1", rd_valid);
    end
    repeat (2) step(0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_back_to_back();
    int vcnt = 0;
    for (int i = 0; i < 64; i++) step(0, 0, 1, 6'(i), 43'({$urandom(), $urandom()}), 0);
    for (int i = 0; i < 66; i++) begin
      if (i >= 2 && rd_valid) vcnt++;
      if (i < 64) step(1, 6'(i), 1, 6'(i + 32), 43'({$urandom(), $urandom()}), 0);
      else        step(0, 0, 0, 0, '0, 0);
    end
    if (rd_valid) vcnt++;
    total = total + 1;
    if (vcnt != 64) begin
      bad = bad + 1;
      $display("FAIL b2b_valids: got %0d want 64", vcnt);
    end
    repeat (2) step(0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_init_req();
    int cnt = 0;
    drive(0, 0, 1, 7, 43'h5A5, 0);
    #1;
    total = total + 1;
    if (w_drop !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL drop_idle: w_drop=%b want 0", w_drop);
    end
    @(negedge nclk);
    step(0, 0, 1, 3, 43'h333, 1);
    tb_busy = 1'b1;
    for (int k = 0; k < 100; k++) begin
      drive(0, 0, k == 10, 3, 43'h4_4444, k == 20);
      #1;
      if (init_busy) cnt++;
      if (k == 10) begin
        total = total + 1;
        if (w_drop !== 1'b1) begin
          bad = bad + 1;
          $display("FAIL drop_sweep: w_drop=%b want 1", w_drop);
        end
      end
      @(negedge nclk);
    end
    total = total + 1;
    if (cnt != 64) begin
      bad = bad + 1;
      $display("FAIL init_req_sweep: init_busy cycles=%0d want 64", cnt);
    end
    clear_model();
    step(1, 3, 0, 0, '0, 0);
    step(1, 7, 0, 0, '0, 0);
    step(1, 63, 0, 0, '0, 0);
    repeat (3) step(0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_parity();
    logic [42:0] d;
    d = 43'h2_AAAA_5555;
    step(0, 0, 1, 10, 43'h1_0F0F, 0);
    drive(0, 0, 1, 9, d, 0);
    corrupt = {^d, d ^ 43'h80};
    model[9] = d ^ 43'h80;
    mperr[9] = 1'b1;
    force dut.wr_entry = corrupt;
    @(posedge nclk);
    #1;
    release dut.wr_entry;
    @(negedge nclk);
    step(1, 9, 0, 0, '0, 0);
    step(1, 10, 0, 0, '0, 0);
    repeat (3) step(0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1, 10, 43'h6_6666, 0);
    step(0, 0, 0, 0, '0, 1);
    tb_busy = 1'b1;
    for (int k = 0; k < 19; k++) step(0, 0, 0, 0, '0, 0);
    step(1, 10, 0, 0, '0, 0);
    drive(0, 0, 0, 0, '0, 0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    total = total + 1;
    if (rd_valid !== 1'b0 || init_busy !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL mid_rst: rd_valid=%b init_busy=%b want 0/1", rd_valid, init_busy);
    end
    repeat (2) @(negedge nclk);
    rst = 1'b0;
    count_sweep("mid_rst_sweep");
    clear_model();
    step(1, 10, 0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0);
    repeat (3) step(0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_back_to_back();
    test_init_req();
    test_parity();
    test_reset_mid();
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d reads never returned", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
